sram_arbiter: RTL and testbench

Shares one single-port `sram1rw` between `NREQ` requesters, e.g. fetch and load/store, using round-robin arbitration. Each requester gets a valid/ready request channel and a valid/ready response channel. The block accounts for the SRAM's one-cycle read latency and holds each response in a per-port one-entry skid buffer until the requester accepts it. It sits between the core-side memory ports and the SRAM macro in `system`.

---
 rtl/c_pkg.sv | 4 +
 rtl/mem_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/sram_arbiter.sv | 104 ++++++++++
 tb/tb_sram_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/c_pkg.sv
// Core-wide configuration constants shared by the memory subsystem.
package C;
    localparam int XLEN = 32;
endpackage

// File: rtl/mem_pkg.sv
// Shared memory-port request/response types used by SRAM-facing blocks.
package mem_pkg;
    localparam int MEM_AW = 20;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [C::XLEN-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [C::XLEN-1:0] rdata;
    } mem_rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, searching from last_grant+1.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [LGW-1:0]  last_grant_i,
    output logic [NREQ-1:0] grant_o
);
    logic           found;
    logic [LGW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        // k runs 1..NREQ so the previous winner is considered last
        for (int k = 1; k <= NREQ; k++) begin
            idx = LGW'((int'(last_grant_i) + k) % NREQ);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between NREQ requesters with round-robin grant,
// one-cycle read latency tracking and a one-entry response skid buffer per port.
module sram_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = MEM_AW,
    parameter int DATA_WIDTH = C::XLEN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NREQ-1:0]                      req_valid_i,
    output logic [NREQ-1:0]                      req_ready_o,
    input  logic [NREQ-1:0]                      req_we_i,
    input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [NREQ-1:0][DATA_WIDTH-1:0]      req_wdata_i,
    output logic [NREQ-1:0]                      rsp_valid_o,
    input  logic [NREQ-1:0]                      rsp_ready_i,
    output logic [NREQ-1:0][DATA_WIDTH-1:0]      rsp_rdata_o,
    output logic                                 mem_we_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);
    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]                 inflight_q, inflight_d;
    logic [NREQ-1:0]                 inflight_we_q, inflight_we_d;
    logic [NREQ-1:0]                 hold_valid_q, hold_valid_d;
    logic [NREQ-1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [LGW-1:0]                  last_grant_q, last_grant_d;

    logic [NREQ-1:0]                 slot_free;
    logic [NREQ-1:0]                 eligible;
    logic [NREQ-1:0]                 grant;
    logic [LGW-1:0]                  grant_idx;
    logic [NREQ-1:0][DATA_WIDTH-1:0] live_data;

    // Eligibility deliberately depends on rsp_ready_i, never on mem_rdata_i.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot_free[i] = !hold_valid_q[i] && (!inflight_q[i] || rsp_ready_i[i]);
        end
        eligible = req_valid_i & slot_free & {NREQ{!rst}};
    end

    rr_arbiter #(.NREQ(NREQ), .LGW(LGW)) u_rr (
        .valid_i      (eligible),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = LGW'(i);
        end
    end

    assign req_ready_o = grant;
    assign mem_we_o    = (|grant) & req_we_i[grant_idx];
    assign mem_addr_o  = (|grant) ? req_addr_i[grant_idx]  : '0;
    assign mem_wdata_o = (|grant) ? req_wdata_i[grant_idx] : '0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            live_data[i]   = inflight_we_q[i] ? '0 : mem_rdata_i;
            rsp_valid_o[i] = !rst && (hold_valid_q[i] || inflight_q[i]);
            rsp_rdata_o[i] = hold_valid_q[i] ? hold_data_q[i] : live_data[i];
        end
    end

    always_comb begin
        inflight_d    = grant;
        inflight_we_d = grant & req_we_i;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        last_grant_d  = (|grant) ? grant_idx : last_grant_q;
        for (int i = 0; i < NREQ; i++) begin
            if (hold_valid_q[i]) begin
                if (rsp_ready_i[i]) hold_valid_d[i] = 1'b0;
            end else if (inflight_q[i] && !rsp_ready_i[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = live_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q    <= '0;
            inflight_we_q <= '0;
            hold_valid_q  <= '0;
            hold_data_q   <= '0;
            last_grant_q  <= LGW'(NREQ - 1);
        end else begin
            inflight_q    <= inflight_d;
            inflight_we_q <= inflight_we_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            last_grant_q  <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_arbiter;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_ready, req_we;
    logic [1:0][19:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid, rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic             mem_we;
    logic [19:0]      mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;
    logic [31:0]      mem [256];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.NREQ(2), .ADDR_WIDTH(20), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // sram1rw model: read data appears the cycle after the address is sampled
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        else n_pass++;
    endtask

    // A held response and a new arrival on the same port must never coexist
    always @(negedge clk) begin
        if (!rst && |(dut.hold_valid_q & dut.inflight_q))
            chk("hold_overlap", 32'(dut.hold_valid_q & dut.inflight_q), 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int prevg;
        int preva;
        int g;
        int a;
        int i0;
        int i1;
        int rdy_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem_rdata = '0;

        // Reset with every port requesting
        rst = 1'b1; req_valid = 2'b11; req_we = 2'b11; rsp_ready = 2'b11;
        req_addr = '0; req_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            tick();
        end
        rst = 1'b0; req_we = 2'b00; req_addr[0] = 20'h5; req_addr[1] = 20'h6;
        settle();
        chk("first_grant", 32'(req_ready), 32'h1);
        chk("first_addr", 32'(mem_addr), 32'h5);
        tick();
        req_valid = 2'b10;
        settle();
        chk("p0_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("p0_rsp_data", rsp_rdata[0], 32'hA000_0005);
        chk("p1_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        settle();
        chk("p1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("p1_rsp_data", rsp_rdata[1], 32'hA000_0006);
        tick();

        // Write then read on port 0
        req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 20'h10; req_wdata[0] = 32'hDEAD;
        settle();
        chk("wr_grant", 32'(req_ready), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEAD);
        tick();
        req_we = 2'b00;
        settle();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_zero", rsp_rdata[0], 32'h0);
        chk("rd_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        settle();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rd_rsp_data", rsp_rdata[0], 32'hDEAD);
        tick();

        // Contention: last winner was port 0, so port 1 leads the alternation
        i0 = 0; i1 = 0; prevg = -1; preva = 0;
        for (int c = 0; c < 8; c++) begin
            g = (c % 2 == 0) ? 1 : 0;
            req_valid = {i1 < 4, i0 < 4};
            req_addr[0] = 20'(i0);
            req_addr[1] = 20'(4 + i1);
            a = (g == 0) ? i0 : 4 + i1;
            settle();
            chk("cont_grant", 32'(req_ready), 32'(1 << g));
            chk("cont_addr", 32'(mem_addr), 32'(a));
            if (prevg >= 0) begin
                chk("cont_rsp_valid", 32'(rsp_valid), 32'(1 << prevg));
                chk("cont_rsp_data", rsp_rdata[prevg], 32'hA000_0000 | 32'(preva));
            end
            if (g == 0) i0++; else i1++;
            prevg = g; preva = a;
            tick();
        end
        req_valid = 2'b00;
        settle();
        chk("cont_last_valid", 32'(rsp_valid), 32'(1 << prevg));
        chk("cont_last_data", rsp_rdata[prevg], 32'hA000_0000 | 32'(preva));
        tick();

        // Backpressure on port 1
        req_valid = 2'b10; req_addr[1] = 20'h20;
        settle();
        chk("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        rsp_ready = 2'b01; req_valid = 2'b11; req_addr[1] = 20'h21;
        for (int k = 0; k < 5; k++) begin
            req_addr[0] = 20'(32'h30 + k);
            settle();
            chk("bp_grant0_only", 32'(req_ready), 32'h1);
            chk("bp_p1_valid", 32'(rsp_valid[1]), 32'h1);
            chk("bp_p1_data", rsp_rdata[1], 32'hA000_0020);
            if (k > 0) chk("bp_p0_data", rsp_rdata[0], 32'hA000_0030 + 32'(k - 1));
            tick();
        end
        rsp_ready = 2'b11; req_valid = 2'b10;
        settle();
        chk("bp_rel_valid", 32'(rsp_valid), 32'h3);
        chk("bp_rel_p0", rsp_rdata[0], 32'hA000_0034);
        chk("bp_rel_p1", rsp_rdata[1], 32'hA000_0020);
        tick();
        settle();
        chk("bp_regrant1", 32'(req_ready), 32'h2);
        chk("bp_drained", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = 2'b00;
        settle();
        chk("bp_next_data", rsp_rdata[1], 32'hA000_0021);
        chk("bp_next_valid", 32'(rsp_valid), 32'h2);
        tick();

        // Back-to-back reads on port 0
        rdy_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            req_valid = 2'b01; req_addr[0] = 20'(32'h40 + k);
            settle();
            if (req_ready[0]) rdy_cnt++;
            if (k > 0) chk("b2b_data", rsp_rdata[0], 32'hA000_0040 + 32'(k - 1));
            tick();
        end
        req_valid = 2'b00;
        settle();
        chk("b2b_ready_cycles", 32'(rdy_cnt), 32'd16);
        chk("b2b_last_data", rsp_rdata[0], 32'hA000_004F);
        tick();

        // Reset the cycle after a grant
        req_valid = 2'b10; req_addr[1] = 20'h50;
        settle();
        chk("mid_grant1", 32'(req_ready), 32'h2);
        tick();
        rst = 1'b1; req_valid = 2'b11; req_addr[0] = 20'h60;
        settle();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        settle();
        chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        chk("mid_restart_p0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        settle();
        chk("mid_p0_valid", 32'(rsp_valid), 32'h1);
        chk("mid_p0_data", rsp_rdata[0], 32'hA000_0060);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
